servo_multi: RTL and testbench
==============================

Name: servo_multi

Overview:
- Multi-channel hobby-servo PWM generator; parametrised successor to the single-channel 8-bit servo driver.
- Drives CHANNELS independent servo outputs from one shared frame counter. Per-channel pulse width and enable are double-buffered so updates land only on frame boundaries (no runt or stretched pulses).
- Optional staggered pulse starts spread supply current across channels.
- Sits between the control/register logic and the servo output pins.

Parameters:
- CHANNELS, 4, number of servo outputs (1..16)
- VAL_W, 8, position command width per channel
- CLK_HZ, 50000000, input clock frequency in Hz
- FRAME_US, 20000, PWM frame period in microseconds
- MIN_US, 1000, pulse width for val=0
- MAX_US, 2000, nominal full-scale pulse width
- STAGGER_US, 0, start offset between consecutive channels; 0 means all channels start together

Ports:
- clk, in, 1: system clock, single domain
- rst, in, 1: asynchronous, active-low reset
- val, in, CHANNELS*VAL_W: packed position commands; channel k uses bits [k*VAL_W +: VAL_W]
- en, in, CHANNELS: per-channel enable, captured together with val
- load, in, 1: one-cycle strobe that captures val and en into the shadow registers
- upd_pend, out, 1: shadow holds values not yet applied
- frame_start, out, 1: one-cycle pulse at the start of each frame
- sig, out, CHANNELS: servo PWM outputs

Behaviour:
- Derived constants (elaboration time):
  - CYC_US = CLK_HZ/1000000
  - FRAME_CYC = FRAME_US*CYC_US
  - MIN_CYC = MIN_US*CYC_US
  - STEP_CYC = ((MAX_US-MIN_US)*CYC_US) >> VAL_W (floor)
  - OFF_CYC = STAGGER_US*CYC_US
- Elaboration must fail if (CHANNELS-1)*OFF_CYC + MIN_CYC + (2^VAL_W-1)*STEP_CYC >= FRAME_CYC. Pulses therefore never wrap across a frame.
- Per-channel width: width_k = MIN_CYC + val_act_k*STEP_CYC. Pulse offset: off_k = k*OFF_CYC. Width arithmetic is unsigned and sized to hold FRAME_CYC.
- Frame counter fcnt counts 0..FRAME_CYC-1 and wraps to 0. It is reset to 0 and increments every clock.
- frame_start and sig are registered from fcnt comparisons with identical latency, so they are cycle-aligned to each other.
  - frame_start is high for exactly one cycle per frame.
  - sig[k] rises exactly off_k cycles after frame_start rises and stays high exactly width_k cycles when en_act[k]=1.
  - sig[k] stays 0 for the whole frame when en_act[k]=0.
- Shadow (pending) registers: when load=1, val_sh<=val, en_sh<=en, and upd_pend<=1. A later load before the transfer overwrites the shadow; last write wins.
- Transfer: in the cycle where fcnt==FRAME_CYC-1 and upd_pend==1, val_act<=val_sh, en_act<=en_sh, and upd_pend<=0. The new values govern the frame that starts next.
- Load and transfer in the same cycle: transfer copies the pre-load shadow, the new load is written to the shadow, and upd_pend stays 1. The new values apply one frame later.
- A load mid-pulse never changes the current frame's pulses.
- Reset values: sig=0, frame_start=0, upd_pend=0, fcnt=0, val_act=0, en_act=0, val_sh=0, en_sh=0. After reset all outputs stay low until the first transfer.
- Reset asserted mid-frame or mid-pulse forces sig low immediately (asynchronous) and discards both active and shadow contents.
- The first frame_start occurs one clock after reset is released.

Decomposition:
- Package servo_pkg holds:
  - derived-constant functions (us-to-cycles, width computation)
  - the elaboration-time parameter legality check
- Sub-module servo_chan (one instance per channel, generate loop), containing:
  - the shadow/active val and en registers
  - the width computation
  - the registered sig comparator, taking fcnt, the transfer strobe, and load as inputs
- Top level owns fcnt, frame_start, upd_pend, and the transfer strobe.

Test Plan (defaults unless noted; FRAME_CYC=1000000, MIN_CYC=50000, STEP_CYC=195):
- Reset behaviour: hold rst=0 for 5 cycles, then release, with no load -> sig=0 for 3 frames, frame_start period exactly 1000000 cycles, upd_pend=0.
- Single channel: load val[ch0]=255, en=0001 mid-frame -> upd_pend=1 until the frame end. From the next frame_start, sig[0] is high for 99725 cycles; other channels stay low.
- Multi-value update: load ch0=0, ch1=127, ch2=255, ch3=64, en=1111 -> next frame widths are 50000 / 74765 / 99725 / 62480 cycles, all rising with frame_start.
- Stagger: STAGGER_US=2000, all channels at val=0 -> sig[k] rises 100000*k cycles after frame_start, each high for 50000 cycles.
- Boundary timing:
  - load ch0 127->255 in the cycle fcnt==FRAME_CYC-1 -> the next frame uses the old shadow value, upd_pend stays 1, and the following frame is 99725 cycles.
  - load during an active pulse -> the current pulse width is unchanged.
- Reset mid-pulse: assert rst=0 while sig[0]=1 -> sig[0] drops within the same cycle with no clock. After release, all channels stay low and upd_pend=0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and elaboration helpers for the multi-channel servo PWM generator.
// All arithmetic here runs at elaboration time only.
package servo_pkg;

   function automatic int cyc_per_us(input int clk_hz);
      return clk_hz / 1000000;
   endfunction

   function automatic int us_to_cyc(input int us, input int clk_hz);
      return us * cyc_per_us(clk_hz);
   endfunction

   function automatic int step_cyc(input int min_us, input int max_us,
                                   input int clk_hz, input int val_w);
      return ((max_us - min_us) * cyc_per_us(clk_hz)) >> val_w;
   endfunction

   // Cycle index (from frame start) at which the last possible pulse ends.
   function automatic longint last_edge(input int channels, input int val_w, input int clk_hz,
                                        input int min_us, input int max_us, input int stagger_us);
      return longint'(channels - 1) * longint'(us_to_cyc(stagger_us, clk_hz))
           + longint'(us_to_cyc(min_us, clk_hz))
           + ((longint'(1) << val_w) - 1) * longint'(step_cyc(min_us, max_us, clk_hz, val_w));
   endfunction

   function automatic bit params_ok(input int channels, input int val_w, input int clk_hz,
                                    input int frame_us, input int min_us, input int max_us,
                                    input int stagger_us);
      return (channels >= 1) && (channels <= 16) && (cyc_per_us(clk_hz) >= 1)
          && (max_us >= min_us)
          && (last_edge(channels, val_w, clk_hz, min_us, max_us, stagger_us)
              < longint'(us_to_cyc(frame_us, clk_hz)));
   endfunction

   function automatic int cnt_width(input int frame_cyc);
      return $clog2(frame_cyc + 1);
   endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: shadow/active command registers and the registered pulse comparator.
// The active copy only changes on the frame-boundary transfer strobe from the top level.
module servo_chan
   import servo_pkg::*;
#(
   parameter int VAL_W    = 8,
   parameter int CW       = 20,
   parameter int MIN_CYC  = 50000,
   parameter int STEP_CYC = 195,
   parameter int OFF_CYC  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CW-1:0]    fcnt,
   input  logic             xfer,
   input  logic             load,
   input  logic [VAL_W-1:0] val_in,
   input  logic             en_in,
   output logic             sig
);

   logic [VAL_W-1:0] val_sh;
   logic [VAL_W-1:0] val_act;
   logic             en_sh;
   logic             en_act;
   logic [CW-1:0]    width_c;
   logic [CW-1:0]    end_c;
   logic             in_win;

   assign width_c = CW'(MIN_CYC) + CW'(val_act) * CW'(STEP_CYC);
   assign end_c   = CW'(OFF_CYC) + width_c;

   // A zero offset would make the lower bound a constant-true compare.
   if (OFF_CYC == 0) begin : g_no_off
      assign in_win = (fcnt < end_c);
   end else begin : g_off
      assign in_win = (fcnt >= CW'(OFF_CYC)) && (fcnt < end_c);
   end

   // Transfer reads the pre-load shadow when load and transfer share a cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_sh  <= '0;
         en_sh   <= 1'b0;
         val_act <= '0;
         en_act  <= 1'b0;
         sig     <= 1'b0;
      end else begin
         if (load) begin
            val_sh <= val_in;
            en_sh  <= en_in;
         end
         if (xfer) begin
            val_act <= val_sh;
            en_act  <= en_sh;
         end
         sig <= en_act && in_win;
      end
   end

endmodule

// File: rtl/servo_multi.sv
// Multi-channel hobby-servo PWM generator with one shared frame counter and
// frame-boundary double-buffered updates.
module servo_multi
   import servo_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int VAL_W      = 8,
   parameter int CLK_HZ     = 50000000,
   parameter int FRAME_US   = 20000,
   parameter int MIN_US     = 1000,
   parameter int MAX_US     = 2000,
   parameter int STAGGER_US = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*VAL_W-1:0] val,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      load,
   output logic                      upd_pend,
   output logic                      frame_start,
   output logic [CHANNELS-1:0]       sig
);

   localparam int FRAME_CYC = us_to_cyc(FRAME_US, CLK_HZ);
   localparam int MIN_CYC   = us_to_cyc(MIN_US, CLK_HZ);
   localparam int STEP_CYC  = step_cyc(MIN_US, MAX_US, CLK_HZ, VAL_W);
   localparam int OFF_CYC   = us_to_cyc(STAGGER_US, CLK_HZ);
   localparam int CW        = cnt_width(FRAME_CYC);

   if (!params_ok(CHANNELS, VAL_W, CLK_HZ, FRAME_US, MIN_US, MAX_US, STAGGER_US)) begin : g_bad
      $error("servo_multi: pulses would not fit inside one frame");
   end

   logic [CW-1:0] fcnt;
   logic          xfer;

   assign xfer = upd_pend && (fcnt == CW'(FRAME_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fcnt        <= '0;
         frame_start <= 1'b0;
         upd_pend    <= 1'b0;
      end else begin
         fcnt        <= (fcnt == CW'(FRAME_CYC - 1)) ? '0 : fcnt + 1'b1;
         frame_start <= (fcnt == '0);
         // A load coinciding with the transfer keeps the flag set for the next frame.
         if (load) begin
            upd_pend <= 1'b1;
         end else if (xfer) begin
            upd_pend <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      servo_chan #(
         .VAL_W    (VAL_W),
         .CW       (CW),
         .MIN_CYC  (MIN_CYC),
         .STEP_CYC (STEP_CYC),
         .OFF_CYC  (k * OFF_CYC)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .fcnt   (fcnt),
         .xfer   (xfer),
         .load   (load),
         .val_in (val[k*VAL_W +: VAL_W]),
         .en_in  (en[k]),
         .sig    (sig[k])
      );
   end

endmodule

// File: tb/tb_servo_multi.sv
// Bench for servo_multi with a shrunk timebase: 1 cycle/us, 1000-cycle frames,
// MIN 100 cycles, STEP 2 cycles; a second instance adds a 100-cycle stagger.
module tb_servo_multi;

   localparam int FRAME = 1000;
   localparam int OFF   = 100;

   typedef int arr4_t[4];
   typedef struct {
      logic [31:0] val;
      logic [3:0]  en;
      arr4_t       len;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] val = '0;
   logic [3:0]  en = '0;
   logic        load = 1'b0;
   logic        upd_pend, frame_start;
   logic [3:0]  sig;
   logic        upd_pend_st, frame_start_st;
   logic [3:0]  sig_st;

   int n_checks = 0;
   int n_errors = 0;
   int m_rise[4], m_len[4], s_rise[4], s_len[4];
   int fs_cnt, fs_end;
   vec_t vecs[4];

   always #5 clk = ~clk;

   servo_multi #(
      .CHANNELS(4), .VAL_W(8), .CLK_HZ(1000000), .FRAME_US(1000),
      .MIN_US(100), .MAX_US(612), .STAGGER_US(0)
   ) dut (
      .clk(clk), .rst(rst), .val(val), .en(en), .load(load),
      .upd_pend(upd_pend), .frame_start(frame_start), .sig(sig)
   );

   servo_multi #(
      .CHANNELS(4), .VAL_W(8), .CLK_HZ(1000000), .FRAME_US(1000),
      .MIN_US(100), .MAX_US(612), .STAGGER_US(100)
   ) dut_st (
      .clk(clk), .rst(rst), .val(val), .en(en), .load(load),
      .upd_pend(upd_pend_st), .frame_start(frame_start_st), .sig(sig_st)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Observe one whole frame from its frame_start cycle; optionally pulse load twice.
   task automatic measure(input int la, input logic [31:0] va, input logic [3:0] ea,
                          input int lb, input logic [31:0] vb, input logic [3:0] eb);
      int n = 0;
      while (!frame_start && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (!frame_start) chk("fs_timeout", 0, 1);
      for (int k = 0; k < 4; k++) begin
         m_rise[k] = -1; m_len[k] = 0; s_rise[k] = -1; s_len[k] = 0;
      end
      fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (frame_start) fs_cnt++;
         for (int k = 0; k < 4; k++) begin
            if (sig[k]) begin
               if (m_rise[k] < 0) m_rise[k] = i;
               m_len[k]++;
            end
            if (sig_st[k]) begin
               if (s_rise[k] < 0) s_rise[k] = i;
               s_len[k]++;
            end
         end
         if ((la >= 0 && i == la + 1) || (lb >= 0 && i == lb + 1))
            chk($sformatf("pend_set_%0d", i), int'(upd_pend), 1);
         if (i == la) begin
            val = va; en = ea; load = 1'b1;
         end else if (i == lb) begin
            val = vb; en = eb; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      fs_end = int'(frame_start);
   endtask

   task automatic check_frame(input string tag, input arr4_t e);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_len%0d", tag, k), m_len[k], e[k]);
         chk($sformatf("%s_rise%0d", tag, k), m_rise[k], (e[k] > 0) ? 0 : -1);
         chk($sformatf("%s_stlen%0d", tag, k), s_len[k], e[k]);
         chk($sformatf("%s_strise%0d", tag, k), s_rise[k], (e[k] > 0) ? OFF * k : -1);
      end
      chk($sformatf("%s_fs_count", tag), fs_cnt, 1);
      chk($sformatf("%s_fs_period", tag), fs_end, 1);
   endtask

   initial begin
      vecs[0].val = {8'd0, 8'd0, 8'd0, 8'd255};    vecs[0].en = 4'b0001; vecs[0].len = '{610, 0, 0, 0};
      vecs[1].val = {8'd40, 8'd30, 8'd20, 8'd10};  vecs[1].en = 4'b1010; vecs[1].len = '{0, 140, 0, 180};
      vecs[2].val = {8'd0, 8'd0, 8'd0, 8'd0};      vecs[2].en = 4'b1111; vecs[2].len = '{100, 100, 100, 100};
      vecs[3].val = {8'd64, 8'd255, 8'd127, 8'd0}; vecs[3].en = 4'b1111; vecs[3].len = '{100, 354, 610, 228};

      // Reset state and idle frames
      repeat (5) @(negedge clk);
      chk("rst_sig", int'(sig), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_pend", int'(upd_pend), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("first_fs", int'(frame_start), 1);
      for (int f = 0; f < 3; f++) begin
         measure(-1, '0, '0, -1, '0, '0);
         check_frame($sformatf("idle%0d", f), '{0, 0, 0, 0});
         chk($sformatf("idle%0d_pend", f), int'(upd_pend), 0);
      end

      // Vector table: each load lands mid-pulse of the frame showing the previous vector
      measure(50, vecs[0].val, vecs[0].en, -1, '0, '0);
      for (int v = 0; v < 4; v++) begin
         chk($sformatf("vec%0d_pend_clear", v), int'(upd_pend), 0);
         if (v < 3) measure(50, vecs[v+1].val, vecs[v+1].en, -1, '0, '0);
         else       measure(-1, '0, '0, -1, '0, '0);
         check_frame($sformatf("vec%0d", v), vecs[v].len);
      end

      // Load 127, then 255 exactly in the last cycle of the frame
      measure(50, 32'd127, 4'b0001, FRAME - 2, 32'd255, 4'b0001);
      check_frame("edge_cur", vecs[3].len);
      chk("edge_pend_kept", int'(upd_pend), 1);
      measure(-1, '0, '0, -1, '0, '0);
      check_frame("edge_old", '{354, 0, 0, 0});
      chk("edge_pend_clear", int'(upd_pend), 0);
      measure(-1, '0, '0, -1, '0, '0);
      check_frame("edge_new", '{610, 0, 0, 0});

      // Asynchronous reset in the middle of a pulse with a pending update
      repeat (5) @(negedge clk);
      val = {8'd200, 8'd200, 8'd200, 8'd200}; en = 4'b1111; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_sig0", int'(sig[0]), 1);
      chk("pre_rst_pend", int'(upd_pend), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_sig", int'(sig), 0);
      chk("async_sig_st", int'(sig_st), 0);
      chk("async_pend", int'(upd_pend), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rerst_first_fs", int'(frame_start), 1);
      for (int f = 0; f < 2; f++) begin
         measure(-1, '0, '0, -1, '0, '0);
         check_frame($sformatf("post_rst%0d", f), '{0, 0, 0, 0});
         chk($sformatf("post_rst%0d_pend", f), int'(upd_pend), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
